sodor5_instr_feeder: RTL

Program-streaming instruction source that sits directly upstream of the Sodor 5-stage core's instruction-memory response port. It drives `io_imem_resp_bits_data`.
- A 16-entry program buffer is loaded through a write port, then replayed in order, one instruction per cycle.
- Supports one-shot and loop modes and a stall input, and tracks issue count.
- NOP (`addi x0,x0,0`) is driven whenever no program instruction is being presented.
- Replaces the free-running cycle-indexed program array in directed Sodor 5 trace benches.

---
 rtl/sodor5_instr_feeder.sv | 93 +++++++++
 1 files changed

// File: rtl/sodor5_instr_feeder.sv
// sodor5_instr_feeder: replays a loaded program buffer into the Sodor 5-stage imem response port,
// one instruction per cycle, with one-shot/loop modes, stall, stop and a saturating issue counter.
module sodor5_instr_feeder #(
    parameter int          DEPTH     = 16,
    parameter int          WORD_SIZE = 32,
    parameter logic [31:0] NOP_INSN  = 32'h00000013,
    parameter int          IDX_W     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_en,
    input  logic [IDX_W-1:0]     load_addr,
    input  logic [WORD_SIZE-1:0] load_data,
    input  logic [IDX_W:0]       prog_len,
    input  logic                 loop_mode,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 stall,
    output logic [WORD_SIZE-1:0] instr,
    output logic                 instr_valid,
    output logic [IDX_W-1:0]     pc_idx,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          issued_count
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               r_state, w_next;
    logic [WORD_SIZE-1:0] r_buf [DEPTH];
    logic [IDX_W:0]       r_len;
    logic                 r_loop;
    logic [IDX_W-1:0]     r_pc;
    logic [WORD_SIZE-1:0] r_instr;
    logic                 r_valid;
    logic [15:0]          r_cnt;
    logic                 w_run, w_accept, w_issue, w_last;

    assign w_run    = r_state == RUN;
    assign w_accept = !w_run && start;
    assign w_issue  = w_run && !stop && !stall;
    assign w_last   = {1'b0, r_pc} == r_len - (IDX_W+1)'(1);

    always_comb begin
        w_next = r_state;
        if (w_accept)
            w_next = prog_len == '0 ? DONE : RUN;
        else if (w_run && stop)
            w_next = IDLE;
        else if (w_issue && w_last && !r_loop)
            w_next = DONE;
    end

    // Buffer survives reset so a program can be rerun after an abort.
    always_ff @(posedge clk)
        if (load_en && !w_run)
            r_buf[load_addr] <= load_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_loop  <= 1'b0;
            r_pc    <= '0;
            r_instr <= WORD_SIZE'(NOP_INSN);
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_len  <= prog_len;
                r_loop <= loop_mode;
                r_pc   <= '0;
                r_cnt  <= '0;
            end
            if (w_issue) begin
                r_instr <= r_buf[r_pc];
                r_valid <= 1'b1;
                r_cnt   <= &r_cnt ? r_cnt : r_cnt + 16'd1;
                r_pc    <= w_last ? (r_loop ? '0 : r_pc) : r_pc + 1'b1;
            end else if (!(w_run && stall && !stop)) begin
                r_instr <= WORD_SIZE'(NOP_INSN);
                r_valid <= 1'b0;
            end
        end
    end

    assign instr        = r_instr;
    assign instr_valid  = r_valid;
    assign pc_idx       = r_pc;
    assign busy         = r_state == RUN;
    assign done         = r_state == DONE;
    assign issued_count = r_cnt;
endmodule
